// File: rtl/nf10_upb_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : nf10_upb_frame_checker
// Brief    : AXI4-Stream sink with NF10 tuser sideband that qualifies frames:
//            payload pattern, tkeep shape, packet_length, sideband stability,
//            oversize and per-frame sequence continuity. Keeps saturating
//            frame/error/loss counters and can throttle tready from an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module nf10_upb_frame_checker #(
    parameter int          C_TDATA_WIDTH = 256,
    parameter int          C_MAX_BEATS   = 256,
    parameter logic [15:0] C_LFSR_SEED   = 16'hACE1
) (
    input  logic                         axi_aclk,
    input  logic                         RESET,
    input  logic [C_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [13:0]                  s_axis_tuser_packet_length,
    input  logic [2:0]                   s_axis_tuser_in_port,
    input  logic [7:0]                   s_axis_tuser_out_port,
    input  logic [2:0]                   s_axis_tuser_in_vport,
    input  logic [7:0]                   s_axis_tuser_out_vport,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [1:0]                   cfg_throttle,
    input  logic                         cfg_clear,
    output logic [31:0]                  frame_count,
    output logic [7:0]                   error_count,
    output logic [15:0]                  lost_count,
    output logic                         locked,
    output logic                         error_pulse
);

    localparam int c_keep_w = C_TDATA_WIDTH / 8;
    localparam int c_pop_w  = $clog2(c_keep_w + 1);
    localparam logic [c_keep_w-1:0] c_keep_one = {{(c_keep_w-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [15:0]         r_lfsr;
    logic                w_lfsr_fb;
    logic                r_tready;

    logic [15:0]         r_beat;        // index of the next beat within the frame
    logic [15:0]         r_seq;         // sequence number captured on beat 0
    logic [21:0]         r_side;        // sideband captured on beat 0
    logic                r_frame_err;   // sticky error for the frame in flight

    logic                r_cmp_valid;   // completion pending for the counter stage
    logic                r_cmp_err;
    logic [15:0]         r_cmp_seq;

    logic [31:0]         r_frame_cnt;
    logic [7:0]          r_err_cnt;
    logic [15:0]         r_lost_cnt;
    logic                r_locked;
    logic [15:0]         r_expected;
    logic                r_error_pulse;

    logic                w_accept;
    logic                w_first;
    logic [15:0]         w_seq;
    logic [15:0]         w_idx;
    logic [31:0]         w_exp_word;
    logic [c_keep_w-1:0] w_byte_bad;
    logic [c_pop_w-1:0]  w_popcnt;
    logic [31:0]         w_exp_len;
    logic                w_keep_contig;
    logic                w_keep_bad;
    logic                w_len_bad;
    logic                w_side_bad;
    logic                w_over;
    logic                w_beat_err;
    logic                w_frame_err;
    logic [21:0]         w_side_now;
    logic [15:0]         w_gap;
    logic [16:0]         w_lost_sum;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Throttle LFSR free-runs every cycle regardless of the handshake.
    always_ff @(posedge axi_aclk) begin
        if (RESET) begin
            r_lfsr <= C_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Registered tready from the throttle mode decode.
    always_ff @(posedge axi_aclk) begin
        if (RESET) begin
            r_tready <= 1'b0;
        end else begin
            case (cfg_throttle)
                2'd0:    r_tready <= 1'b1;
                2'd1:    r_tready <= r_lfsr[0];
                2'd2:    r_tready <= (r_lfsr[1:0] == 2'b00);
                default: r_tready <= 1'b0;
            endcase
        end
    end

    assign w_accept   = s_axis_tvalid & r_tready;
    assign w_first    = (r_state == S_IDLE);
    assign w_seq      = w_first ? s_axis_tdata[31:16] : r_seq;
    assign w_idx      = w_first ? 16'd0 : r_beat;
    assign w_exp_word = {w_seq, w_idx};
    assign w_side_now = {s_axis_tuser_in_port, s_axis_tuser_out_port,
                         s_axis_tuser_in_vport, s_axis_tuser_out_vport};

    // Each enabled byte must match its byte of the replicated 32-bit pattern word.
    for (genvar gi = 0; gi < c_keep_w; gi++) begin : g_byte
        assign w_byte_bad[gi] = s_axis_tkeep[gi] &
                                (s_axis_tdata[8*gi +: 8] != w_exp_word[8*(gi%4) +: 8]);
    end

    // Number of valid bytes in the current beat.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < c_keep_w; i++) begin
            w_popcnt = w_popcnt + {{(c_pop_w-1){1'b0}}, s_axis_tkeep[i]};
        end
    end

    assign w_exp_len     = (32'(c_keep_w) * {16'd0, w_idx}) + {{(32-c_pop_w){1'b0}}, w_popcnt};
    // Contiguous-from-bit-0 masks are exactly those where mask & (mask+1) is zero.
    assign w_keep_contig = (s_axis_tkeep != '0) &&
                           ((s_axis_tkeep & (s_axis_tkeep + c_keep_one)) == '0);
    assign w_keep_bad    = s_axis_tlast ? !w_keep_contig : !(&s_axis_tkeep);
    assign w_len_bad     = s_axis_tlast && ({18'd0, s_axis_tuser_packet_length} != w_exp_len);
    assign w_side_bad    = !w_first && (w_side_now != r_side);
    assign w_over        = ({16'd0, w_idx} >= 32'(C_MAX_BEATS));
    assign w_beat_err    = (|w_byte_bad) | w_keep_bad | w_len_bad | w_side_bad | w_over;
    assign w_frame_err   = (r_frame_err & !w_first) | w_beat_err;

    // Frame state register.
    always_ff @(posedge axi_aclk) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a single-beat frame never leaves S_IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !s_axis_tlast) w_state_nxt = S_BODY;
            S_BODY: if (w_accept && s_axis_tlast)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-frame tracking and hand-off of the finished frame to the counter stage.
    always_ff @(posedge axi_aclk) begin
        if (RESET) begin
            r_beat      <= 16'd0;
            r_seq       <= 16'd0;
            r_side      <= 22'd0;
            r_frame_err <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            r_cmp_seq   <= 16'd0;
        end else begin
            r_cmp_valid <= w_accept & s_axis_tlast;
            if (w_accept) begin
                if (w_first) begin
                    r_seq  <= s_axis_tdata[31:16];
                    r_side <= w_side_now;
                end
                r_beat      <= (w_idx == 16'hFFFF) ? 16'hFFFF : w_idx + 16'd1;
                r_frame_err <= s_axis_tlast ? 1'b0 : w_frame_err;
                if (s_axis_tlast) begin
                    r_cmp_err <= w_frame_err;
                    r_cmp_seq <= w_seq;
                end
            end
        end
    end

    assign w_gap      = r_cmp_seq - r_expected;
    assign w_lost_sum = {1'b0, r_lost_cnt} + {1'b0, w_gap};

    // Saturating counters and sequence tracking; a clear overrides a same-edge completion.
    always_ff @(posedge axi_aclk) begin
        if (RESET || cfg_clear) begin
            r_frame_cnt   <= 32'd0;
            r_err_cnt     <= 8'd0;
            r_lost_cnt    <= 16'd0;
            r_locked      <= 1'b0;
            r_expected    <= 16'd0;
            r_error_pulse <= 1'b0;
        end else begin
            r_error_pulse <= 1'b0;
            if (r_cmp_valid) begin
                if (r_frame_cnt != 32'hFFFF_FFFF) begin
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end
                if (r_cmp_err) begin
                    r_error_pulse <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                if (!r_locked) begin
                    r_locked <= 1'b1;
                end else if (r_cmp_seq != r_expected) begin
                    r_lost_cnt <= w_lost_sum[16] ? 16'hFFFF : w_lost_sum[15:0];
                end
                r_expected <= r_cmp_seq + 16'd1;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign frame_count   = r_frame_cnt;
    assign error_count   = r_err_cnt;
    assign lost_count    = r_lost_cnt;
    assign locked        = r_locked;
    assign error_pulse   = r_error_pulse;

endmodule
`default_nettype wire

// File: tb/tb_nf10_upb_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nf10_upb_frame_checker
// Brief    : Table-driven self-checking bench for nf10_upb_frame_checker,
//            plus directed sequences for throttle-off, mid-frame reset and
//            clear colliding with a completion.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nf10_upb_frame_checker;

    localparam int W    = 256;
    localparam int KW   = W / 8;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [13:0]   plen;
    logic [2:0]    in_port;
    logic [7:0]    out_port;
    logic [2:0]    in_vport;
    logic [7:0]    out_vport;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [1:0]    cfg_throttle;
    logic          cfg_clear;
    logic [31:0]   frame_count;
    logic [7:0]    error_count;
    logic [15:0]   lost_count;
    logic          locked;
    logic          error_pulse;

    int n_total = 0;
    int n_pass  = 0;
    int pulses  = 0;
    int r0_low  = 0;
    int m1_hi   = 0;
    int m1_lo   = 0;
    bit watch0  = 0;
    bit watch1  = 0;

    nf10_upb_frame_checker #(
        .C_TDATA_WIDTH (W),
        .C_MAX_BEATS   (MAXB),
        .C_LFSR_SEED   (16'hACE1)
    ) dut (
        .axi_aclk                   (clk),
        .RESET                      (rst),
        .s_axis_tdata               (s_axis_tdata),
        .s_axis_tkeep               (s_axis_tkeep),
        .s_axis_tuser_packet_length (plen),
        .s_axis_tuser_in_port       (in_port),
        .s_axis_tuser_out_port      (out_port),
        .s_axis_tuser_in_vport      (in_vport),
        .s_axis_tuser_out_vport     (out_vport),
        .s_axis_tvalid              (s_axis_tvalid),
        .s_axis_tready              (s_axis_tready),
        .s_axis_tlast               (s_axis_tlast),
        .cfg_throttle               (cfg_throttle),
        .cfg_clear                  (cfg_clear),
        .frame_count                (frame_count),
        .error_count                (error_count),
        .lost_count                 (lost_count),
        .locked                     (locked),
        .error_pulse                (error_pulse)
    );

    always #5 clk = ~clk;

    // Observers sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (error_pulse) pulses++;
        if (watch0 && !s_axis_tready) r0_low++;
        if (watch1) begin
            if (s_axis_tready) m1_hi++;
            else               m1_lo++;
        end
    end

    typedef struct {
        bit          clr;
        int          mode;
        int          seq;
        int          nbeats;
        logic [31:0] last_keep;
        int          plen;
        int          flip_beat;
        int          flip_byte;
        bit          side_chg;
        int          exp_frames;
        int          exp_errs;
        int          exp_lost;
        int          exp_pulse;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(bit clr, int mode, int seq, int nb, logic [31:0] lk, int pl,
                                int fbeat, int fbyte, bit sc, int ef, int ee, int el, int ep);
        vec_t v;
        v.clr = clr; v.mode = mode; v.seq = seq; v.nbeats = nb; v.last_keep = lk;
        v.plen = pl; v.flip_beat = fbeat; v.flip_byte = fbyte; v.side_chg = sc;
        v.exp_frames = ef; v.exp_errs = ee; v.exp_lost = el; v.exp_pulse = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic drive(input int seq, input int k, input logic [31:0] keep, input bit last,
                         input int pl, input int fbyte, input bit alt);
        logic [W-1:0] d;
        for (int l = 0; l < W/32; l++) d[32*l +: 32] = {seq[15:0], k[15:0]};
        if (fbyte >= 0) d[8*fbyte +: 8] = d[8*fbyte +: 8] ^ 8'hFF;
        s_axis_tdata  = d;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        plen          = pl[13:0];
        in_port       = 3'd1;
        out_port      = alt ? 8'h08 : 8'h04;
        in_vport      = 3'd0;
        out_vport     = 8'h10;
        s_axis_tvalid = 1'b1;
    endtask

    // Present one beat and hold it through the edge that accepts it.
    task automatic beat(input int seq, input int k, input logic [31:0] keep, input bit last,
                        input int pl, input int fbyte, input bit alt);
        int waitn = 0;
        @(negedge clk);
        drive(seq, k, keep, last, pl, fbyte, alt);
        while (!s_axis_tready && waitn < 300) begin
            @(negedge clk);
            waitn++;
        end
        if (!s_axis_tready) begin
            n_total++;
            $display("FAIL ready_timeout: tready %0b after %0d cycles, required 1", s_axis_tready, waitn);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int seq, input int nb, input logic [31:0] lk, input int pl,
                              input int fbeat, input int fbyte, input bit sc, input bit clr_end);
        for (int k = 0; k < nb; k++) begin
            beat(seq, k, (k == nb-1) ? lk : 32'hFFFF_FFFF, (k == nb-1), pl,
                 (k == fbeat) ? fbyte : -1, sc && (k > 0));
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_clear     = clr_end;
        @(negedge clk);
        cfg_clear     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p0;
        int hi;
        vec_t v;

        for (int i = 0; i < 10; i++)
            vecs[i] = mk(0, 0, i, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, i+1, 0, 0, 0);
        for (int i = 10; i < 15; i++)
            vecs[i] = mk(0, 1, i, 4, 32'h0000_000F, 100, -1, -1, 0, i+1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 2, 0, 0, 0);
        vecs[17] = mk(0, 0, 2, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 3, 0, 0, 0);
        vecs[18] = mk(0, 0, 3, 2, 32'hFFFF_FFFF, 64,  1, 17, 0, 4, 1, 0, 1);
        vecs[19] = mk(1, 0, 0, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 1, 0, 0, 0);
        vecs[20] = mk(0, 0, 1, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 2, 0, 0, 0);
        vecs[21] = mk(0, 0, 5, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 3, 0, 3, 0);
        vecs[22] = mk(0, 0, 6, 2, 32'hFFFF_FFFF, 64, -1, -1, 0, 4, 0, 3, 0);
        vecs[23] = mk(1, 0, 7, 4, 32'h0000_000F, 99, -1, -1, 0, 1, 1, 0, 1);
        vecs[24] = mk(0, 0, 8, 4, 32'h0000_000D, 100, -1, -1, 0, 2, 2, 0, 1);
        vecs[25] = mk(0, 0, 9, MAXB+1, 32'hFFFF_FFFF, 32*(MAXB+1), -1, -1, 0, 3, 3, 0, 1);
        vecs[26] = mk(0, 0, 10, 2, 32'hFFFF_FFFF, 64, -1, -1, 1, 4, 4, 0, 1);
        vecs[27] = mk(0, 2, 12, 3, 32'hFFFF_FFFF, 96, -1, -1, 0, 5, 4, 1, 0);

        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        s_axis_tkeep = '0; plen = '0; in_port = '0; out_port = '0; in_vport = '0;
        out_vport = '0; cfg_throttle = 2'd0; cfg_clear = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tready", {31'd0, s_axis_tready}, 0);
        check("rst_frames", frame_count, 0);
        check("rst_errors", {24'd0, error_count}, 0);
        check("rst_lost", {16'd0, lost_count}, 0);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_pulse", {31'd0, error_pulse}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            v = vecs[i];
            if (v.clr) begin
                cfg_clear = 1'b1;
                @(negedge clk);
                cfg_clear = 1'b0;
            end
            cfg_throttle = v.mode[1:0];
            @(negedge clk);
            watch0 = (v.mode == 0);
            watch1 = (v.mode == 1);
            p0 = pulses;
            send_frame(v.seq, v.nbeats, v.last_keep, v.plen, v.flip_beat, v.flip_byte,
                       v.side_chg, 1'b0);
            watch0 = 0;
            watch1 = 0;
            check($sformatf("v%0d_frames", i), frame_count, v.exp_frames);
            check($sformatf("v%0d_errors", i), {24'd0, error_count}, v.exp_errs);
            check($sformatf("v%0d_lost", i), {16'd0, lost_count}, v.exp_lost);
            check($sformatf("v%0d_locked", i), {31'd0, locked}, 1);
            check($sformatf("v%0d_pulses", i), pulses - p0, v.exp_pulse);
        end
        check("mode0_ready_low_cycles", r0_low, 0);
        check("mode1_ready_high_seen", {31'd0, (m1_hi > 0)}, 1);
        check("mode1_ready_low_seen", {31'd0, (m1_lo > 0)}, 1);

        // Throttle mode 3: a presented beat must never be taken.
        cfg_throttle = 2'd3;
        repeat (3) @(negedge clk);
        drive(40, 0, 32'hFFFF_FFFF, 1'b1, 32, -1, 1'b0);
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_axis_tready) hi++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check("mode3_ready_high_cycles", hi, 0);
        check("mode3_frames", frame_count, 5);

        // Reset on beat 2 of a 4-beat frame, then clean frames.
        cfg_throttle = 2'd0;
        repeat (2) @(negedge clk);
        beat(20, 0, 32'hFFFF_FFFF, 1'b0, 128, -1, 1'b0);
        beat(20, 1, 32'hFFFF_FFFF, 1'b0, 128, -1, 1'b0);
        @(negedge clk);
        drive(20, 2, 32'hFFFF_FFFF, 1'b0, 128, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("midrst_frames", frame_count, 0);
        check("midrst_locked", {31'd0, locked}, 0);
        send_frame(30, 2, 32'hFFFF_FFFF, 64, -1, -1, 1'b0, 1'b0);
        check("after_rst_frames", frame_count, 1);
        check("after_rst_errors", {24'd0, error_count}, 0);
        check("after_rst_locked", {31'd0, locked}, 1);

        // Clear on the very edge the next completion lands: clear wins.
        p0 = pulses;
        send_frame(31, 2, 32'hFFFF_FFFF, 64, -1, -1, 1'b0, 1'b1);
        check("clr_collide_frames", frame_count, 0);
        check("clr_collide_locked", {31'd0, locked}, 0);
        check("clr_collide_lost", {16'd0, lost_count}, 0);
        check("clr_collide_pulses", pulses - p0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nf10_upb_frame_checker.md
Name: nf10_upb_frame_checker

Overview:
Synthesisable, parametrised successor to the simulation-only stream checker used on interconnect benches. It sinks an AXI4-Stream with the NF10 tuser sideband and verifies the payload pattern, tkeep shape, packet_length and per-frame sequence numbers. It keeps saturating error, loss and frame counters, and can throttle tready under an LFSR for backpressure testing. It sits on arbiter-side outputs, in hardware or on benches, to qualify links end to end.

Parameters:
C_TDATA_WIDTH, 256, stream width in bits; a multiple of 32, from 32 to 256
C_MAX_BEATS, 256, beats per frame above which the frame is flagged oversize
C_LFSR_SEED, 16'hACE1, reset value of the throttle LFSR; must be non-zero

Ports:
axi_aclk  in  1  clock
RESET  in  1  synchronous, active-high reset
s_axis_tdata  in  C_TDATA_WIDTH  payload
s_axis_tkeep  in  C_TDATA_WIDTH/8  byte enables
s_axis_tuser_packet_length  in  14  frame length in bytes
s_axis_tuser_in_port  in  3  sideband
s_axis_tuser_out_port  in  8  sideband
s_axis_tuser_in_vport  in  3  sideband
s_axis_tuser_out_vport  in  8  sideband
s_axis_tvalid  in  1  valid
s_axis_tready  out  1  ready
s_axis_tlast  in  1  last beat
cfg_throttle  in  2  0 always ready; 1 ready when lfsr[0]; 2 ready when lfsr[1:0]==0; 3 ready held low
cfg_clear  in  1  clears the counters and lock
frame_count  out  32  frames completed, saturating
error_count  out  8  frames with at least one error, saturating at 255
lost_count  out  16  sequence numbers skipped, saturating
locked  out  1  sequence reference established
error_pulse  out  1  one-cycle strobe for each errored frame

Behaviour:
- Interface: one clock, axi_aclk; reset RESET is synchronous and active-high.
- A beat is accepted on the axi_aclk edge where s_axis_tvalid and s_axis_tready are both high.
- Reset values: all counters 0, locked 0, error_pulse 0, s_axis_tready 0, LFSR = C_LFSR_SEED, FSM in S_IDLE. s_axis_tready follows cfg_throttle from the first cycle after reset.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, independent of the handshake. s_axis_tready is registered from the mode decode.
- Payload pattern: beat k of a frame carries the 32-bit word {seq[15:0], k[15:0]} replicated across all 32-bit lanes. seq is taken from beat 0, lane 0, bits [31:16]. Only bytes whose tkeep bit is set are compared.
- tkeep rule: all ones on non-last beats. On the last beat it must be non-zero and contiguous from bit 0.
- Length rule: at tlast, packet_length must equal (C_TDATA_WIDTH/8)*(beats-1) + popcount(last tkeep).
- Sideband rule: tuser fields are captured on beat 0. Any change on a later beat of the same frame is an error.
- Oversize: a beat count above C_MAX_BEATS sets the frame error flag. The frame continues to be consumed until tlast.
- FSM:
  - S_IDLE -> S_BODY on acceptance of a non-last beat. A single-beat frame (tlast on beat 0) completes directly.
  - S_BODY -> S_IDLE on acceptance of tlast.
  - Beat counter is 16-bit and saturates at its maximum.
- Completion, registered one cycle after the tlast handshake:
  - frame_count increments.
  - If the frame error flag is set: error_count increments once and error_pulse goes high for exactly 1 cycle.
  - Sequence update, applied to every frame, errored or not:
    - If locked is 0: set locked, expected = seq+1.
    - Else if seq != expected: lost_count += (seq-expected) mod 2^16, saturating; expected = seq+1.
    - Else: expected = seq+1.
- Saturation: counters hold at their maximum value and never wrap.
- cfg_clear: zeroes all counters and locked on the next edge without touching the FSM. A frame in flight still completes and is counted. A completion landing on the same edge as cfg_clear is discarded, i.e. the clear wins.
- RESET mid-frame: the partial frame is dropped and no counter moves. The next beat with tvalid is treated as beat 0.
- cfg_throttle = 3: no beats are accepted. Input state is ignored.

Test Plan:
- Mode 0, 10 frames of 64 bytes each, seq 0..9, correct pattern -> frame_count=10, error_count=0, lost_count=0, locked=1, tready constantly 1.
- Mode 1, 5 frames of 100 bytes each (last tkeep=0x0000000F, 4 beats) -> tready toggles per LFSR, frame_count=5, error_count=0.
- Frame seq 3 with byte 17 of beat 1 flipped -> error_count=1, a single error_pulse, frame_count still increments.
- Sequence 0,1,5,6 -> lost_count=3, error_count=0.
- packet_length=99 on a 100-byte frame, then last tkeep=0x0000000D on the next frame -> error_count=2.
- RESET asserted on beat 2 of a 4-beat frame, then 1 clean frame -> frame_count=1. cfg_clear coincident with that frame's completion -> frame_count=0.
